// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Misaligned-access trapping in mem_stage_lsu is enabled by MEM_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } lsu_state_t;

  // Halfword needs a[0]=0, word needs a[1:0]=0; funct3[1:0] encodes the size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    r = 1'b0;
    case (f3[1:0])
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    be = 4'hF;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data lane selection and sign/zero extension for the MEM stage.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[7:0];
    case (a)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = a[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_BU:   result = {24'h000000, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_HU:   result = {16'h0000, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: data-memory handshake, load alignment, MEM/WB registers.
// Define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on misalign_o.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          mem_r_i,
  input  logic          mem_w_i,
  input  logic [2:0]    funct3_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [31:0]   alu_i,
  input  logic [4:0]    rd_i,
  input  logic          reg_w_i,
  output logic          dm_req_o,
  output logic          dm_we_o,
  output logic [AW-1:0] dm_addr_o,
  output logic [3:0]    dm_be_o,
  output logic [31:0]   dm_wdata_o,
  input  logic          dm_gnt_i,
  input  logic          dm_rvalid_i,
  input  logic [31:0]   dm_rdata_i,
  output logic          stall_o,
  output logic          wb_reg_w_o,
  output logic [4:0]    wb_rd_o,
  output logic [31:0]   wb_data_o,
  output logic          misalign_o
);

  lsu_state_t  state, state_nxt;
  logic        acc, mis, acc_ok, is_load;
  logic [31:0] ld_data;

  assign acc     = (mem_r_i | mem_w_i) & ~flush_i;
  assign is_load = mem_r_i & ~mem_w_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = acc & is_misaligned(funct3_i, addr_i[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign acc_ok = acc & ~mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // rvalid is ignored in IDLE, so a response arriving after reset is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_ok && is_load && dm_gnt_i) state_nxt = WAIT;
      WAIT: begin
        if (dm_rvalid_i)  state_nxt = IDLE;
        else if (flush_i) state_nxt = DRAIN;
      end
      DRAIN:   if (dm_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dm_req_o = 1'b0;
    stall_o  = 1'b0;
    case (state)
      IDLE: begin
        dm_req_o = acc_ok;
        stall_o  = acc_ok & (is_load | ~dm_gnt_i);
      end
      WAIT:    stall_o = ~dm_rvalid_i & ~flush_i;
      DRAIN:   stall_o = acc_ok;
      default: stall_o = 1'b0;
    endcase
  end

  assign dm_we_o   = mem_w_i;
  assign dm_addr_o = {addr_i[AW-1:2], 2'b00};
  assign dm_be_o   = byte_en(funct3_i, addr_i[1:0]);

  always_comb begin
    dm_wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00:   dm_wdata_o = {4{wdata_i[7:0]}};
      2'b01:   dm_wdata_o = {2{wdata_i[15:0]}};
      default: dm_wdata_o = wdata_i;
    endcase
  end

  lsu_load_align u_align (
    .rdata  (dm_rdata_i),
    .a      (addr_i[1:0]),
    .funct3 (funct3_i),
    .result (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_w_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
    end else if (!stall_o) begin
      if (flush_i || mis) begin
        wb_reg_w_o <= 1'b0;
        wb_rd_o    <= '0;
        wb_data_o  <= '0;
      end else begin
        wb_reg_w_o <= reg_w_i;
        wb_rd_o    <= rd_i;
        wb_data_o  <= is_load ? ld_data : alu_i;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           misalign_q <= 1'b0;
    else if (!stall_o) misalign_q <= mis;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, mem_r_i, mem_w_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, alu_i;
  logic [4:0]  rd_i;
  logic        reg_w_i;
  logic        dm_req_o, dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i, dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic        stall_o, wb_reg_w_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.AW(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .mem_r_i(mem_r_i), .mem_w_i(mem_w_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .alu_i(alu_i),
    .rd_i(rd_i), .reg_w_i(reg_w_i), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
    .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .stall_o(stall_o), .wb_reg_w_o(wb_reg_w_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  task automatic idle_inputs();
    flush_i = 0; mem_r_i = 0; mem_w_i = 0; funct3_i = 3'b000; addr_i = '0;
    wdata_i = '0; alu_i = '0; rd_i = '0; reg_w_i = 0;
    dm_gnt_i = 0; dm_rvalid_i = 0; dm_rdata_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    #2;
    checks++; if (wb_reg_w_o !== 1'b0) begin errors++; $display("FAIL rst_wb_reg_w: got %b expected 0", wb_reg_w_o); end
    checks++; if (wb_rd_o !== 5'd0) begin errors++; $display("FAIL rst_wb_rd: got %0d expected 0", wb_rd_o); end
    checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h expected 0", wb_data_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign_o); end
    checks++; if ({dm_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL rst_req_stall: got %b expected 00", {dm_req_o, stall_o}); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_store_sw();
    mem_w_i = 1; funct3_i = 3'b010; addr_i = 32'h100; wdata_i = 32'hDEADBEEF; dm_gnt_i = 1;
    #1;
    checks++; if ({dm_req_o, dm_we_o} !== 2'b11) begin errors++; $display("FAIL sw_req_we: got %b expected 11", {dm_req_o, dm_we_o}); end
    checks++; if (dm_be_o !== 4'hF) begin errors++; $display("FAIL sw_be: got %b expected 1111", dm_be_o); end
    checks++; if (dm_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", dm_wdata_o); end
    checks++; if (dm_addr_o !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h expected 00000100", dm_addr_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b expected 0", stall_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_store_sb();
    int stall_cnt = 0;
    mem_w_i = 1; funct3_i = 3'b000; addr_i = 32'h103; wdata_i = 32'h0000005A;
    for (int i = 0; i < 3; i++) begin
      dm_gnt_i = (i == 2);
      #1;
      if (stall_o === 1'b1) stall_cnt++;
      if (i == 0) begin
        checks++; if (dm_be_o !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", dm_be_o); end
        checks++; if (dm_wdata_o !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wdata: got %h expected 5a5a5a5a", dm_wdata_o); end
        checks++; if (dm_addr_o !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h expected 00000100", dm_addr_o); end
      end
      checks++; if (dm_req_o !== 1'b1) begin errors++; $display("FAIL sb_req_held: cycle %0d got %b expected 1", i, dm_req_o); end
      tick();
    end
    checks++; if (stall_cnt != 2) begin errors++; $display("FAIL sb_stall_cycles: got %0d expected 2", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input int lat, input logic [31:0] exp);
    mem_r_i = 1; funct3_i = f3; addr_i = a; rd_i = 5'd9; reg_w_i = 1;
    alu_i = 32'h11111111; dm_gnt_i = 1;
    #1;
    checks++; if ({dm_req_o, stall_o, dm_we_o} !== 3'b110) begin errors++; $display("FAIL %s_issue: req/stall/we got %b expected 110", name, {dm_req_o, stall_o, dm_we_o}); end
    tick();
    dm_gnt_i = 0;
    for (int i = 1; i < lat; i++) begin
      #1;
      checks++; if ({dm_req_o, stall_o} !== 2'b01) begin errors++; $display("FAIL %s_wait: req/stall got %b expected 01", name, {dm_req_o, stall_o}); end
      tick();
    end
    dm_rvalid_i = 1; dm_rdata_i = rdata;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL %s_rvalid_stall: got %b expected 0", name, stall_o); end
    tick();
    idle_inputs();
    checks++; if (wb_data_o !== exp) begin errors++; $display("FAIL %s_wb_data: got %h expected %h", name, wb_data_o, exp); end
    checks++; if ({wb_reg_w_o, wb_rd_o} !== {1'b1, 5'd9}) begin errors++; $display("FAIL %s_wb_ctl: got %b/%0d expected 1/9", name, wb_reg_w_o, wb_rd_o); end
  endtask

  task automatic test_flush_drain();
    mem_r_i = 1; funct3_i = 3'b010; addr_i = 32'h200; rd_i = 5'd4; reg_w_i = 1; dm_gnt_i = 1;
    tick();
    dm_gnt_i = 0; flush_i = 1;
    #1;
    checks++; if ({dm_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL flush_wait: req/stall got %b expected 00", {dm_req_o, stall_o}); end
    tick();
    checks++; if ({wb_reg_w_o, wb_rd_o} !== 6'd0) begin errors++; $display("FAIL flush_bubble: got %b/%0d expected 0/0", wb_reg_w_o, wb_rd_o); end
    flush_i = 0; addr_i = 32'h300; rd_i = 5'd6;
    #1;
    checks++; if ({dm_req_o, stall_o} !== 2'b01) begin errors++; $display("FAIL drain_hold: req/stall got %b expected 01", {dm_req_o, stall_o}); end
    tick();
    dm_rvalid_i = 1; dm_rdata_i = 32'hCAFEF00D;
    #1;
    checks++; if ({dm_req_o, stall_o} !== 2'b01) begin errors++; $display("FAIL drain_rvalid: req/stall got %b expected 01", {dm_req_o, stall_o}); end
    tick();
    checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL drain_discard: wb_data got %h expected 0", wb_data_o); end
    dm_rvalid_i = 0; dm_gnt_i = 1;
    #1;
    checks++; if ({dm_req_o, stall_o, dm_addr_o} !== {2'b11, 32'h300}) begin errors++; $display("FAIL drain_reissue: req/stall/addr got %b%b/%h expected 11/00000300", dm_req_o, stall_o, dm_addr_o); end
    tick();
    dm_gnt_i = 0; dm_rvalid_i = 1; dm_rdata_i = 32'h00000042;
    tick();
    checks++; if ({wb_reg_w_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd6, 32'h42}) begin errors++; $display("FAIL drain_next_load: got %b/%0d/%h expected 1/6/00000042", wb_reg_w_o, wb_rd_o, wb_data_o); end
    idle_inputs();
  endtask

  task automatic test_misalign();
    mem_r_i = 1; funct3_i = 3'b010; addr_i = 32'h102; rd_i = 5'd8; reg_w_i = 1;
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    checks++; if ({dm_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL mis_suppress: req/stall got %b expected 00", {dm_req_o, stall_o}); end
    tick();
    idle_inputs();
    checks++; if ({misalign_o, wb_reg_w_o} !== 2'b10) begin errors++; $display("FAIL mis_flag: misalign/reg_w got %b expected 10", {misalign_o, wb_reg_w_o}); end
    tick();
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", misalign_o); end
`else
    dm_gnt_i = 1;
    #1;
    checks++; if ({dm_req_o, dm_addr_o, dm_be_o} !== {1'b1, 32'h100, 4'hF}) begin errors++; $display("FAIL mis_off_req: req/addr/be got %b/%h/%b expected 1/00000100/1111", dm_req_o, dm_addr_o, dm_be_o); end
    tick();
    dm_gnt_i = 0; dm_rvalid_i = 1; dm_rdata_i = 32'hA5A50001;
    tick();
    idle_inputs();
    checks++; if ({misalign_o, wb_data_o} !== {1'b0, 32'hA5A50001}) begin errors++; $display("FAIL mis_off_wb: misalign/data got %b/%h expected 0/a5a50001", misalign_o, wb_data_o); end
`endif
  endtask

  task automatic test_reset_mid();
    alu_i = 32'h77; rd_i = 5'd3; reg_w_i = 1;
    tick();
    checks++; if ({wb_reg_w_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd3, 32'h77}) begin errors++; $display("FAIL alu_pass: got %b/%0d/%h expected 1/3/00000077", wb_reg_w_o, wb_rd_o, wb_data_o); end
    mem_r_i = 1; funct3_i = 3'b010; addr_i = 32'h400; dm_gnt_i = 1;
    tick();
    dm_gnt_i = 0;
    #2;
    rst = 1;
    idle_inputs();
    #1;
    checks++; if ({wb_reg_w_o, wb_rd_o, wb_data_o, misalign_o, dm_req_o, stall_o} !== '0) begin errors++; $display("FAIL rst_async: reg_w/rd/data/mis/req/stall got %b/%0d/%h/%b/%b/%b expected all 0", wb_reg_w_o, wb_rd_o, wb_data_o, misalign_o, dm_req_o, stall_o); end
    tick();
    rst = 0;
    tick();
    dm_rvalid_i = 1; dm_rdata_i = 32'h00000BAD;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL late_rvalid_stall: got %b expected 0", stall_o); end
    tick();
    idle_inputs();
    checks++; if ({wb_reg_w_o, wb_data_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL late_rvalid_wb: got %b/%h expected 0/00000000", wb_reg_w_o, wb_data_o); end
  endtask

  initial begin
    test_reset();
    test_store_sw();
    test_store_sb();
    test_load("lb",  3'b000, 32'h102, 32'h00800000, 3, 32'hFFFFFF80);
    test_load("lbu", 3'b100, 32'h102, 32'h00800000, 3, 32'h00000080);
    test_load("lh",  3'b001, 32'h102, 32'h80010000, 2, 32'hFFFF8001);
    test_load("lhu", 3'b101, 32'h102, 32'h80010000, 1, 32'h00008001);
    test_load("lw",  3'b010, 32'h104, 32'h12345678, 1, 32'h12345678);
    test_flush_drain();
    test_misalign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
